instr_fetch_reg: RTL
====================

// Module: instr_fetch_reg
// PURPOSE
//  Fetch-side instruction register for the multicycle MIPS datapath. On a fetch
//  command from the control FSM it requests one word from instruction memory
//  via req/ack, latches it, and splits it into fields. imm[15:0] drives the
//  sign-extension stage; the other fields go to the register file and control.
// PARAMETERS
//  TIMEOUT_CYCLES  255           max cycles mem_req stays high without mem_ack (>=1)
//  RESET_INSTR     32'h00000000  IR value after reset or flush (MIPS nop)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset_n      in   1   asynchronous active-low reset
//  fetch_start  in   1   control FSM request: fetch word at pc (pulse, 1 cycle)
//  flush        in   1   abort any fetch, invalidate IR
//  pc           in   32  byte address of instruction, sampled with fetch_start
//  mem_req      out  1   memory read request, held until ack/timeout/flush
//  mem_addr     out  32  registered fetch address, stable while mem_req=1
//  mem_ack      in   1   memory: mem_rdata valid this cycle
//  mem_rdata    in   32  instruction word
//  fetch_busy   out  1   1 while in BUSY state
//  fetch_done   out  1   1-cycle pulse: IR loaded with new word
//  fetch_err    out  1   sticky: timeout or misaligned pc; cleared by fetch_start
//  ir_valid     out  1   IR holds a successfully fetched word
//  opcode       out  6   IR[31:26]
//  rs, rt, rd   out  5   IR[25:21], IR[20:16], IR[15:11]
//  shamt        out  5   IR[10:6]
//  funct        out  6   IR[5:0]
//  imm          out  16  IR[15:0], to sign-extend stage
//  jtarget      out  26  IR[25:0]
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, IR=RESET_INSTR, mem_addr=0, mem_req=0,
//   fetch_busy=0, fetch_done=0, fetch_err=0, ir_valid=0, timeout counter=0.
//  Field outputs are pure combinational slices of the IR register.
//  FSM states: IDLE, BUSY.
//  IDLE: fetch_start=1 at edge N -> ir_valid=0, fetch_err=0; if pc[1:0]!=0:
//   fetch_err=1 at N+1, stay IDLE, no mem_req; else mem_addr=pc, mem_req=1,
//   fetch_busy=1, counter=0, state=BUSY at N+1. mem_ack in IDLE is ignored.
//  BUSY: mem_ack sampled only here. mem_ack=1 at edge M -> IR=mem_rdata,
//   ir_valid=1, fetch_done=1 (M+1 only), mem_req=0, state=IDLE at M+1.
//   Zero-wait ack (first BUSY cycle) is legal: done 2 cycles after fetch_start.
//   No ack: counter increments each cycle; at counter==TIMEOUT_CYCLES-1 without
//   ack -> fetch_err=1, mem_req=0, IR unchanged, ir_valid=0, state=IDLE.
//   mem_ack on the final timeout cycle wins (normal completion, no error).
//   fetch_start while BUSY: ignored; pc not resampled, mem_addr stays stable.
//  flush=1 (any state, priority over all else): next edge state=IDLE, mem_req=0,
//   IR=RESET_INSTR, ir_valid=0, fetch_done=0; fetch_err unchanged; a
//   simultaneous mem_ack or fetch_start is discarded.
//  reset_n asserted mid-fetch: immediate return to reset values; mem_req drops
//   asynchronously.
//  IR holds its value between fetches; only fetch completion/flush/reset change it.
// TESTING
//  1 Reset: reset_n=0 mid-BUSY -> mem_req=0 at once, IR=0, ir_valid=0, err=0.
//  2 pc=0x00400004, start; ack after 3 BUSY cycles, rdata=0x8C43FFFC -> mem_addr
//    =0x00400004; done pulse 1 cycle; opcode=0x23 rs=2 rt=3 imm=0xFFFC valid=1.
//  3 Zero-wait ack, rdata=0x00851020 -> done 2 cycles after start; rs=4 rt=5
//    rd=2 shamt=0 funct=0x20; second start in BUSY ignored, mem_addr unchanged.
//  4 TIMEOUT_CYCLES=4, never ack -> mem_req high exactly 4 cycles, then err=1,
//    IR unchanged, valid=0; next start clears err.
//  5 pc=0x00400002 -> err=1 next cycle, mem_req never asserted, state IDLE.
//  6 flush together with mem_ack in BUSY -> IR=RESET_INSTR, valid=0, no done.

Source files
------------

// File: rtl/instr_fetch_reg.sv
// ---------------------------------------------------------------------------
// instr_fetch_reg
//
// Fetch-side instruction register for the multicycle MIPS datapath. When the
// control FSM pulses fetch_start_i, the block issues a single-word read to
// instruction memory over a req/ack handshake. It latches the returned word
// into the IR and presents the IR as decoded instruction fields.
//
// A request that is not acknowledged within TIMEOUT_CYCLES cycles is
// abandoned and reported through the sticky fetch_err_o. A misaligned pc is
// also reported through fetch_err_o. flush_i aborts any fetch and invalidates
// the IR.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles mem_req_o stays high without mem_ack_i (>= 1)
//   RESET_INSTR     IR contents after reset or flush (MIPS nop by default)
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   fetch_start_i  1-cycle request: fetch the word at pc_i
//   flush_i        abort any fetch and invalidate the IR (highest priority)
//   pc_i           byte address of the instruction, sampled with fetch_start_i
//   mem_req_o      memory read request, held until ack, timeout or flush
//   mem_addr_o     registered fetch address, stable while mem_req_o is high
//   mem_ack_i      mem_rdata_i is valid this cycle
//   mem_rdata_i    instruction word from memory
//   fetch_busy_o   a memory request is outstanding
//   fetch_done_o   1-cycle pulse: the IR was just loaded with a new word
//   fetch_err_o    sticky timeout / misalignment flag, cleared by fetch_start_i
//   ir_valid_o     the IR holds a successfully fetched word
//   opcode_o       IR[31:26]
//   rs_o           IR[25:21]
//   rt_o           IR[20:16]
//   rd_o           IR[15:11]
//   shamt_o        IR[10:6]
//   funct_o        IR[5:0]
//   imm_o          IR[15:0], feeds the sign-extension stage
//   jtarget_o      IR[25:0], jump target field
// ---------------------------------------------------------------------------
module instr_fetch_reg #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    // Control FSM side
    input  logic        fetch_start_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,

    // Instruction memory side
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,

    // Status
    output logic        fetch_busy_o,
    output logic        fetch_done_o,
    output logic        fetch_err_o,
    output logic        ir_valid_o,

    // Decoded IR fields
    output logic [5:0]  opcode_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [5:0]  funct_o,
    output logic [15:0] imm_o,
    output logic [25:0] jtarget_o
);

    // The counter only has to reach TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES)
    // bits are enough. Keep at least one bit for the degenerate case.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              pc_misaligned;
    logic              timeout_hit;

    assign pc_misaligned = (pc_i[1:0] != 2'b00);
    assign timeout_hit   = (cnt_q == CntLast);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (flush_i) begin
            // Flush overrides everything: a simultaneous ack or start is
            // dropped. The error flag is deliberately left as it was.
            state_d = StIdle;
            ir_d    = RESET_INSTR;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // mem_ack_i is ignored here; only an outstanding
                    // request can be acknowledged.
                    if (fetch_start_i) begin
                        valid_d = 1'b0;
                        err_d   = 1'b0;
                        if (pc_misaligned) begin
                            err_d = 1'b1;
                        end else begin
                            addr_d  = pc_i;
                            cnt_d   = '0;
                            state_d = StBusy;
                        end
                    end
                end

                StBusy: begin
                    // fetch_start_i is ignored while busy so mem_addr_o stays
                    // stable. An ack on the final timeout cycle still
                    // completes normally because ack is checked first.
                    if (mem_ack_i) begin
                        ir_d    = mem_rdata_i;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else if (timeout_hit) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ir_q    <= RESET_INSTR;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The request is outstanding exactly while in StBusy. Because state_q
    // resets asynchronously, mem_req_o drops as soon as reset is asserted.
    assign mem_req_o    = (state_q == StBusy);
    assign fetch_busy_o = (state_q == StBusy);
    assign mem_addr_o   = addr_q;
    assign fetch_done_o = done_q;
    assign fetch_err_o  = err_q;
    assign ir_valid_o   = valid_q;

    assign opcode_o  = ir_q[31:26];
    assign rs_o      = ir_q[25:21];
    assign rt_o      = ir_q[20:16];
    assign rd_o      = ir_q[15:11];
    assign shamt_o   = ir_q[10:6];
    assign funct_o   = ir_q[5:0];
    assign imm_o     = ir_q[15:0];
    assign jtarget_o = ir_q[25:0];

endmodule
